conv_input_sequencer: RTL
=========================

# conv_input_sequencer

Read-side controller for the pixel FIFO: pops 8-bit pixels one frame at a time in the system clock domain and presents them to the first convolutional layer with a valid/ready handshake. Tags each delivered pixel with raster coordinates and start-of-frame, end-of-line and end-of-frame markers. Absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so it sustains 1 pixel/cycle under downstream backpressure.

## Interface
- IMG_W, 28, pixels per line (≥2)
- IMG_H, 28, lines per frame (≥2)
- i_sys_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse; arms one frame when idle
- i_fifo_valid  in  1  FIFO not-empty (pixel FIFO feature-valid)
- i_fifo_data  in  8  FIFO dout; valid the cycle after o_fifo_rd_en
- o_fifo_rd_en  out  1  FIFO read enable
- i_ready  in  1  conv layer accepts the pixel this cycle
- o_pixel  out  8  pixel to conv layer
- o_pixel_valid  out  1  o_pixel and tags valid
- o_col  out  $clog2(IMG_W)  column of o_pixel
- o_row  out  $clog2(IMG_H)  row of o_pixel
- o_sof  out  1  o_pixel is (0,0)
- o_eol  out  1  o_pixel is in column IMG_W-1
- o_eof  out  1  o_pixel is the last pixel of the frame
- o_busy  out  1  state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse after the last handshake

## Operation
- TOTAL = IMG_W*IMG_H. Internal counter widths: $clog2(TOTAL+1).
- States: IDLE, STREAM, DRAIN.
  - IDLE: i_start → STREAM; read-issue counter and coordinates cleared to 0.
  - STREAM: issue reads; once issue count reaches TOTAL → DRAIN.
  - DRAIN: no reads; after the handshake of the pixel with o_eof → IDLE; o_frame_done pulses in the following cycle.
- i_start outside IDLE is ignored.
- A handshake is o_pixel_valid & i_ready.
- Read rule (combinational from registered state): o_fifo_rd_en = STREAM & i_fifo_valid & (issued < TOTAL) & (held + inflight − handshake < 2).
  - held: buffer occupancy, 0..2.
  - inflight: o_fifo_rd_en from the previous cycle.
  - The FIFO is never overread, and the buffer never overflows.
- Buffer: head register drives o_pixel; skid register second.
  - Returning FIFO data goes to the head if the head is empty or is being handshaken (with the skid empty); otherwise it goes to the skid.
  - On a head handshake with the skid full, the skid moves to the head.
  - Order is strictly FIFO order.
- While o_pixel_valid & !i_ready: o_pixel, o_col, o_row and the tags hold stable.
- Coordinates advance on each handshake: col+1; at col=IMG_W-1, col←0 and row+1. Both wrap to 0 after o_eof.
- Tags are decoded from the head coordinates:
  - o_sof = (row==0 & col==0)
  - o_eol = (col==IMG_W-1)
  - o_eof = o_eol & (row==IMG_H-1)
- Reset mid-frame: all state is cleared. A FIFO read in flight at reset is discarded, so that pixel is lost; the frame must be restarted upstream.

## Timing
- Reset values: o_fifo_rd_en 0, o_pixel 0, o_pixel_valid 0, o_col 0, o_row 0, o_sof 0, o_eol 0, o_eof 0, o_busy 0, o_frame_done 0. State IDLE; held and inflight 0.
- Cycle 0: i_start. Cycle 1: STREAM, o_busy=1, first o_fifo_rd_en (if i_fifo_valid). Cycle 2: data on i_fifo_data, captured at the end of the cycle. Cycle 3: o_pixel_valid=1 with o_sof=1.
- Read to o_pixel_valid latency: 2 cycles with an empty buffer.
- With i_fifo_valid and i_ready held high: one handshake per cycle; the last handshake occurs in cycle TOTAL+2 after the start cycle (TOTAL+2 cycles after i_start). o_frame_done follows one cycle later, and o_busy drops in the same cycle as o_frame_done.
- FIFO empty mid-frame: o_fifo_rd_en=0. Buffered pixels still deliver; o_pixel_valid drops once the buffer is empty.
- Simultaneous return and head handshake with held=1 and the skid empty: the returning data goes directly to the head; held stays 1.

## Test plan
- Reset, then pulse i_start with the FIFO preloaded with 784 pixels 0..255 repeating and i_ready=1 → rd_en from cycle 1. Pixel 0 with o_sof appears at cycle 3. o_eol at every col 27; o_eof on pixel 783 at (27,27). o_frame_done one cycle later; exactly 784 reads.
- i_ready toggling 1/0 every cycle → output held stable during stalls. Never more than 2 reads outstanding beyond consumption. Data order matches the FIFO; no loss or duplication.
- i_ready=0 for 10 cycles mid-line → exactly 2 reads beyond the last handshake, then rd_en=0. On i_ready=1, the two buffered pixels deliver back-to-back, followed by continuous streaming.
- i_fifo_valid drops for 5 cycles at pixel 100 → no rd_en during the gap; o_pixel_valid drops after the buffer drains. Streaming resumes with pixel 100 at the correct (col 16, row 3).
- i_start pulsed during STREAM and DRAIN → ignored; total reads remain 784. A second i_start after o_frame_done → new frame with o_sof at (0,0).
- i_rst asserted at pixel 300 with a read in flight → all outputs take reset values the next cycle, state IDLE. A subsequent i_start restarts at (0,0).

Source files
------------

// File: rtl/conv_input_sequencer.sv
// conv_input_sequencer
// Read-side controller for the pixel FIFO. Pops one frame of 8-bit pixels
// and presents them to the first conv layer over a valid/ready handshake,
// tagged with raster coordinates and sof/eol/eof markers. A 2-entry output
// buffer (head + skid) absorbs the FIFO's one-cycle read latency so the
// stream sustains one pixel per cycle under backpressure.
//
// Ports:
//   i_sys_clk     system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_start       one-cycle pulse, arms one frame when idle
//   i_fifo_valid  FIFO not-empty
//   i_fifo_data   FIFO dout, valid the cycle after o_fifo_rd_en
//   o_fifo_rd_en  FIFO read enable
//   i_ready       conv layer accepts the pixel this cycle
//   o_pixel       pixel to conv layer
//   o_pixel_valid o_pixel and tags valid
//   o_col, o_row  coordinates of o_pixel
//   o_sof/o_eol/o_eof  start-of-frame / end-of-line / end-of-frame tags
//   o_busy        controller not idle
//   o_frame_done  one-cycle pulse after the last handshake
module conv_input_sequencer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_fifo_valid,
    input  logic [7:0]               i_fifo_data,
    output logic                     o_fifo_rd_en,
    input  logic                     i_ready,
    output logic [7:0]               o_pixel,
    output logic                     o_pixel_valid,
    output logic [$clog2(IMG_W)-1:0] o_col,
    output logic [$clog2(IMG_H)-1:0] o_row,
    output logic                     o_sof,
    output logic                     o_eol,
    output logic                     o_eof,
    output logic                     o_busy,
    output logic                     o_frame_done
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_RD  = CW'(TOTAL - 1);
    localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] issued;
    logic [1:0]    held;
    logic          inflight;
    logic [7:0]    head;
    logic [7:0]    skid;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          frame_done;

    logic          handshake;
    logic          col_last;
    logic          row_last;
    logic [2:0]    occupancy;

    always_comb begin
        handshake = (held != 2'd0) && i_ready;
        col_last  = (col == COL_LAST);
        row_last  = (row == ROW_LAST);
        // Slots that will be committed after this edge if no new read issues.
        occupancy = {1'b0, held} + {2'b00, inflight} - {2'b00, handshake};
        o_fifo_rd_en = (state == STREAM) && i_fifo_valid &&
                       (issued < TOTAL_C) && (occupancy < 3'd2);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            issued     <= '0;
            held       <= '0;
            inflight   <= 1'b0;
            head       <= '0;
            skid       <= '0;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            inflight   <= o_fifo_rd_en;
            frame_done <= 1'b0;

            // Head/skid update; returning data fills the earliest free slot,
            // bypassing the skid when the head is leaving and the skid is empty.
            if (handshake) begin
                if (held == 2'd2) begin
                    head <= skid;
                    if (inflight) skid <= i_fifo_data;
                end else if (inflight) begin
                    head <= i_fifo_data;
                end
            end else if (inflight) begin
                if (held == 2'd0) head <= i_fifo_data;
                else              skid <= i_fifo_data;
            end
            held <= held + {1'b0, inflight} - {1'b0, handshake};

            // Coordinates always describe the pixel in the head register.
            if (state == IDLE && i_start) begin
                col <= '0;
                row <= '0;
            end else if (handshake) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= STREAM;
                        issued <= '0;
                    end
                end
                STREAM: begin
                    if (o_fifo_rd_en) begin
                        issued <= issued + 1'b1;
                        if (issued == LAST_RD) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (handshake && col_last && row_last) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_pixel       = head;
        o_pixel_valid = (held != 2'd0);
        o_col         = col;
        o_row         = row;
        o_sof         = o_pixel_valid && (col == '0) && (row == '0);
        o_eol         = o_pixel_valid && col_last;
        o_eof         = o_pixel_valid && col_last && row_last;
        o_busy        = (state != IDLE);
        o_frame_done  = frame_done;
    end

endmodule
